// File: rtl/axis_coef_loader_pkg.sv
// Shared constants for the coefficient stream loader: FSM encodings, error codes,
// TKEEP patterns and per-mode beat counts.
package axis_coef_loader_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RECV  = 3'd1;
   localparam logic [2:0] ST_HOLD  = 3'd2;
   localparam logic [2:0] ST_FLUSH = 3'd3;
   localparam logic [2:0] ST_FIN   = 3'd4;

   localparam logic [1:0] ERR_OK         = 2'd0;
   localparam logic [1:0] ERR_EARLY_LAST = 2'd1;
   localparam logic [1:0] ERR_NO_LAST    = 2'd2;
   localparam logic [1:0] ERR_KEEP       = 2'd3;

   localparam logic [7:0] KEEP_FULL = 8'hFF;
   localparam logic [7:0] KEEP_LO   = 8'h0F;

   localparam int NTT_BEATS = 2048;
   localparam int PWM_BEATS = 1024;

   // A low-word-only beat is acceptable solely as the closing beat of a packet.
   function automatic logic keep_legal(input logic [7:0] keep, input logic last);
      return (keep == KEEP_FULL) || ((keep == KEEP_LO) && last);
   endfunction

endpackage

// File: rtl/axis_coef_loader_beat_unpack.sv
// Holds one 64-bit beat and turns it into one or two registered 32-bit RAM writes
// at consecutive word addresses, owning the write pointer.
module beat_unpack
   import axis_coef_loader_pkg::*;
#(
   parameter int PRM_DAXI = 64,
   parameter int PRM_DRAM = 32,
   parameter int PRM_ADDR = 12
) (
   input  logic                iSYS_CLK,
   input  logic                iSYS_RST,
   input  logic                arm,
   input  logic [PRM_ADDR-1:0] base,
   input  logic                load,
   input  logic                lo_only,
   input  logic [PRM_DAXI-1:0] beat,
   output logic                ram_we,
   output logic [PRM_ADDR-1:0] ram_addr,
   output logic [PRM_DRAM-1:0] ram_wdata,
   output logic                hi_pending
);

   logic [PRM_ADDR-1:0] wptr;
   logic [PRM_DRAM-1:0] hi_word;

   // Low word goes out the cycle after acceptance, the high word the cycle after that.
   always_ff @(posedge iSYS_CLK) begin
      if (iSYS_RST) begin
         wptr       <= '0;
         hi_word    <= '0;
         hi_pending <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
      end else begin
         ram_we <= 1'b0;
         if (arm) begin
            wptr       <= base;
            hi_pending <= 1'b0;
         end else if (load) begin
            ram_we     <= 1'b1;
            ram_addr   <= wptr;
            ram_wdata  <= beat[PRM_DRAM-1:0];
            hi_word    <= beat[PRM_DAXI-1:PRM_DRAM];
            hi_pending <= !lo_only;
            wptr       <= wptr + 1'b1;
         end else if (hi_pending) begin
            ram_we     <= 1'b1;
            ram_addr   <= wptr;
            ram_wdata  <= hi_word;
            hi_pending <= 1'b0;
            wptr       <= wptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/axis_coef_loader.sv
// AXI-Stream receiver that unpacks 64-bit coefficient beats into 32-bit RAM writes
// and reports beat-count/TLAST/TKEEP problems to the control FSM.
module axis_coef_loader
   import axis_coef_loader_pkg::*;
#(
   parameter int PRM_DAXI = 64,
   parameter int PRM_DRAM = 32,
   parameter int PRM_ADDR = 12
) (
   input  logic                  iSYS_CLK,
   input  logic                  iSYS_RST,
   input  logic                  iCTL_START,
   input  logic [PRM_ADDR-1:0]   iCTL_BEATS,
   input  logic [PRM_ADDR-1:0]   iCTL_BASE,
   input  logic                  iS_AXIS_TVALID,
   output logic                  oS_AXIS_TREADY,
   input  logic [PRM_DAXI-1:0]   iS_AXIS_TDATA,
   input  logic [PRM_DAXI/8-1:0] iS_AXIS_TKEEP,
   input  logic                  iS_AXIS_TLAST,
   output logic                  oRAM_WE,
   output logic [PRM_ADDR-1:0]   oRAM_ADDR,
   output logic [PRM_DRAM-1:0]   oRAM_WDATA,
   output logic                  oBUSY,
   output logic                  oDONE,
   output logic [1:0]            oERR
);

   logic [2:0]          state;
   logic [PRM_ADDR-1:0] beats;
   logic [PRM_ADDR-1:0] beat_cnt;
   logic [1:0]          err;
   logic                closing;
   logic                hi_pending;
   logic                hs;
   logic                keep_ok;
   logic                at_last;
   logic                arm;
   logic [PRM_ADDR:0]   cnt_inc;

   assign oS_AXIS_TREADY = ((state == ST_RECV) && !closing && (beat_cnt < beats))
                           || (state == ST_FLUSH);
   assign hs      = iS_AXIS_TVALID && oS_AXIS_TREADY;
   assign keep_ok = keep_legal(iS_AXIS_TKEEP, iS_AXIS_TLAST);
   assign cnt_inc = {1'b0, beat_cnt} + 1'b1;
   assign at_last = (cnt_inc == {1'b0, beats});
   assign arm     = (state == ST_IDLE) && iCTL_START;

   assign oBUSY = (state == ST_RECV) || (state == ST_HOLD) || (state == ST_FLUSH);
   assign oDONE = (state == ST_FIN);
   assign oERR  = err;

   // closing marks that the accepted beat ended the load; the FSM only reaches FIN
   // once the last of that beat's words has been issued, so oDONE trails it by one.
   // An early TLAST has already closed the packet, so there is nothing to flush.
   always_ff @(posedge iSYS_CLK) begin
      if (iSYS_RST) begin
         state    <= ST_IDLE;
         beats    <= '0;
         beat_cnt <= '0;
         err      <= ERR_OK;
         closing  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (iCTL_START) begin
                  beats    <= iCTL_BEATS;
                  beat_cnt <= '0;
                  err      <= ERR_OK;
                  closing  <= 1'b0;
                  state    <= (iCTL_BEATS == '0) ? ST_FIN : ST_RECV;
               end
            end
            ST_RECV: begin
               if (closing) begin
                  state <= ST_FIN;
               end else if (hs) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (!keep_ok) begin
                     err   <= ERR_KEEP;
                     state <= iS_AXIS_TLAST ? ST_FIN : ST_FLUSH;
                  end else begin
                     state <= ST_HOLD;
                     if (iS_AXIS_TLAST && !at_last) begin
                        err     <= ERR_EARLY_LAST;
                        closing <= 1'b1;
                     end else if (at_last) begin
                        closing <= 1'b1;
                        if (!iS_AXIS_TLAST) err <= ERR_NO_LAST;
                     end
                  end
               end
            end
            ST_HOLD: begin
               state <= (closing && !hi_pending) ? ST_FIN : ST_RECV;
            end
            ST_FLUSH: begin
               if (hs) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (iS_AXIS_TLAST) state <= ST_FIN;
               end
            end
            ST_FIN: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   beat_unpack #(
      .PRM_DAXI(PRM_DAXI),
      .PRM_DRAM(PRM_DRAM),
      .PRM_ADDR(PRM_ADDR)
   ) u_unpack (
      .iSYS_CLK  (iSYS_CLK),
      .iSYS_RST  (iSYS_RST),
      .arm       (arm),
      .base      (iCTL_BASE),
      .load      (hs && keep_ok && (state == ST_RECV)),
      .lo_only   (iS_AXIS_TKEEP == KEEP_LO),
      .beat      (iS_AXIS_TDATA),
      .ram_we    (oRAM_WE),
      .ram_addr  (oRAM_ADDR),
      .ram_wdata (oRAM_WDATA),
      .hi_pending(hi_pending)
   );

endmodule
